// File: rtl/signed_stream_minmax.sv
// Packet-wise signed min/max/count tracker with a valid/ready result port.
// Define MINMAX_INDEX_EN to add 0-based min/max index outputs.

module comparatorSigned #(
   parameter int N = 8
) (
   input  logic signed [N-1:0] a,
   input  logic signed [N-1:0] b,
   output logic                lt,
   output logic                gt
);
   assign lt = (a < b);
   assign gt = (a > b);
endmodule

module signed_stream_minmax #(
   parameter int N     = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             inValid,
   output logic             inReady,
   input  logic [N-1:0]     inData,
   input  logic             inLast,
   output logic             outValid,
   input  logic             outReady,
   output logic [N-1:0]     outMin,
   output logic [N-1:0]     outMax,
`ifdef MINMAX_INDEX_EN
   output logic [CNT_W-1:0] outMinIdx,
   output logic [CNT_W-1:0] outMaxIdx,
`endif
   output logic [CNT_W-1:0] outCount
);
   typedef enum logic [1:0] {EMPTY, ACCUM, HOLD} state_e;

   state_e            state_q, state_d;
   logic [N-1:0]      min_q, min_d, max_q, max_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              lt_min, gt_max, accept;
`ifdef MINMAX_INDEX_EN
   logic [CNT_W-1:0]  min_idx_q, min_idx_d, max_idx_q, max_idx_d;
`endif

   comparatorSigned #(.N(N)) u_cmp_min (
      .a(inData), .b(min_q), .lt(lt_min), .gt()
   );
   comparatorSigned #(.N(N)) u_cmp_max (
      .a(inData), .b(max_q), .lt(), .gt(gt_max)
   );

   assign inReady  = (state_q != HOLD);
   assign outValid = (state_q == HOLD);
   assign accept   = inValid & inReady;
   assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      max_d   = max_q;
      cnt_d   = cnt_q;
`ifdef MINMAX_INDEX_EN
      min_idx_d = min_idx_q;
      max_idx_d = max_idx_q;
`endif
      case (state_q)
         EMPTY: if (accept) begin
            min_d   = inData;
            max_d   = inData;
            cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef MINMAX_INDEX_EN
            min_idx_d = '0;
            max_idx_d = '0;
`endif
            state_d = inLast ? HOLD : ACCUM;
         end
         ACCUM: if (accept) begin
            cnt_d = cnt_inc;
            // strict compares: ties keep the earliest occurrence
            if (lt_min) begin
               min_d = inData;
`ifdef MINMAX_INDEX_EN
               min_idx_d = cnt_q;
`endif
            end
            if (gt_max) begin
               max_d = inData;
`ifdef MINMAX_INDEX_EN
               max_idx_d = cnt_q;
`endif
            end
            if (inLast) state_d = HOLD;
         end
         HOLD: if (outReady) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= EMPTY;
         min_q   <= '0;
         max_q   <= '0;
         cnt_q   <= '0;
`ifdef MINMAX_INDEX_EN
         min_idx_q <= '0;
         max_idx_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         max_q   <= max_d;
         cnt_q   <= cnt_d;
`ifdef MINMAX_INDEX_EN
         min_idx_q <= min_idx_d;
         max_idx_q <= max_idx_d;
`endif
      end
   end

   assign outMin   = min_q;
   assign outMax   = max_q;
   assign outCount = cnt_q;
`ifdef MINMAX_INDEX_EN
   assign outMinIdx = min_idx_q;
   assign outMaxIdx = max_idx_q;
`endif

endmodule

// File: tb/tb_signed_stream_minmax.sv
// Directed bench: an 8-bit-counter instance and a 3-bit-counter instance share stimulus.

module tb_signed_stream_minmax;
   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       inValid = 1'b0;
   logic [7:0] inData = '0;
   logic       inLast = 1'b0;
   logic       outReady = 1'b0;

   logic       inReady, outValid, inReady3, outValid3;
   logic [7:0] outMin, outMax, outCount, outMin3, outMax3;
   logic [2:0] outCount3;
`ifdef MINMAX_INDEX_EN
   logic [7:0] outMinIdx, outMaxIdx;
   logic [2:0] outMinIdx3, outMaxIdx3;
`endif

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   signed_stream_minmax #(.N(8), .CNT_W(8)) dut (
      .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
      .inData(inData), .inLast(inLast), .outValid(outValid), .outReady(outReady),
      .outMin(outMin), .outMax(outMax),
`ifdef MINMAX_INDEX_EN
      .outMinIdx(outMinIdx), .outMaxIdx(outMaxIdx),
`endif
      .outCount(outCount)
   );

   signed_stream_minmax #(.N(8), .CNT_W(3)) dut3 (
      .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady3),
      .inData(inData), .inLast(inLast), .outValid(outValid3), .outReady(outReady),
      .outMin(outMin3), .outMax(outMax3),
`ifdef MINMAX_INDEX_EN
      .outMinIdx(outMinIdx3), .outMaxIdx(outMaxIdx3),
`endif
      .outCount(outCount3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send(input logic [7:0] d, input logic last);
      inValid = 1'b1;
      inData  = d;
      inLast  = last;
      @(posedge clk); #1;
      inValid = 1'b0;
      inLast  = 1'b0;
   endtask

   task automatic drain();
      outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
      chk("drain_valid", outValid, 1'b0);
      chk("drain_ready", inReady, 1'b1);
   endtask

   initial begin
      // reset state (inReady is 1 while in reset)
      #2;
      chk("rst_ready", inReady, 1'b1);
      chk("rst_valid", outValid, 1'b0);
      chk("rst_min", outMin, 8'h00);
      chk("rst_max", outMax, 8'h00);
      chk("rst_cnt", outCount, 8'd0);
      @(negedge clk); rstN = 1'b1;
      @(posedge clk); #1;

      // 1: full signed range, back-to-back
      send(8'd5, 0); send(8'hFD, 0); send(8'h7F, 0); send(8'h80, 1);
      chk("t1_valid", outValid, 1'b1);
      chk("t1_ready", inReady, 1'b0);
      chk("t1_min", outMin, 8'h80);
      chk("t1_max", outMax, 8'h7F);
      chk("t1_cnt", outCount, 8'd4);
      chk("t1_cnt3", outCount3, 3'd4);
      drain();

      // 2: single-sample packet
      send(8'hFF, 1);
      chk("t2_valid", outValid, 1'b1);
      chk("t2_min", outMin, 8'hFF);
      chk("t2_max", outMax, 8'hFF);
      chk("t2_cnt", outCount, 8'd1);

      // 3: backpressure for 5 cycles with inValid held high
      inValid = 1'b1; inData = 8'h55;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("t3_valid", outValid, 1'b1);
         chk("t3_ready", inReady, 1'b0);
         chk("t3_min", outMin, 8'hFF);
         chk("t3_cnt", outCount, 8'd1);
      end
      inValid = 1'b0;
      drain();

      // 4: ties keep earliest occurrence
      send(8'd3, 0); send(8'd3, 0); send(8'hF9, 0);
      send(8'd9, 0); send(8'hF9, 0); send(8'd9, 1);
      chk("t4_valid", outValid, 1'b1);
      chk("t4_min", outMin, 8'hF9);
      chk("t4_max", outMax, 8'd9);
      chk("t4_cnt", outCount, 8'd6);
`ifdef MINMAX_INDEX_EN
      chk("t4_minidx", outMinIdx, 8'd2);
      chk("t4_maxidx", outMaxIdx, 8'd3);
`endif
      drain();

      // 5: async reset mid-packet, then a fresh packet
      send(8'd10, 0); send(8'd20, 0);
      rstN = 1'b0;
      #1;
      chk("t5_min", outMin, 8'h00);
      chk("t5_max", outMax, 8'h00);
      chk("t5_cnt", outCount, 8'd0);
      chk("t5_ready", inReady, 1'b1);
      chk("t5_valid", outValid, 1'b0);
      #2 rstN = 1'b1;
      @(posedge clk); #1;
      send(8'd1, 0); send(8'd2, 1);
      chk("t5b_valid", outValid, 1'b1);
      chk("t5b_min", outMin, 8'd1);
      chk("t5b_max", outMax, 8'd2);
      chk("t5b_cnt", outCount, 8'd2);
      drain();

      // 6: 10 samples, with an idle cycle carrying a stray inLast
      send(8'd4, 0); send(8'hFE, 0); send(8'd6, 0); send(8'hCE, 0);
      inValid = 1'b0; inLast = 1'b1; inData = 8'h80;
      @(posedge clk); #1;
      inLast = 1'b0;
      chk("t6_idle_valid", outValid, 1'b0);
      chk("t6_idle_min", outMin, 8'hCE);
      chk("t6_idle_cnt", outCount, 8'd4);
      send(8'd0, 0); send(8'd33, 0); send(8'd100, 0);
      send(8'hFF, 0); send(8'hA6, 0); send(8'd7, 1);
      chk("t6_valid", outValid, 1'b1);
      chk("t6_min", outMin, 8'hA6);
      chk("t6_max", outMax, 8'd100);
      chk("t6_cnt", outCount, 8'd10);
      chk("t6_valid3", outValid3, 1'b1);
      chk("t6_min3", outMin3, 8'hA6);
      chk("t6_max3", outMax3, 8'd100);
      chk("t6_cnt3", outCount3, 3'd7);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
